// File: rtl/shift_sequencer.sv
// Multi-cycle controller for the MIC-1 shifter: repeats single-step SLL8/SRA1
// operations through an external combinational shifter to build N-step shifts.
module shift_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned SLL_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              OP,
  input  logic [CNT_W-1:0]  COUNT,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] SH_OPND,
  output logic [1:0]        SET,
  input  logic [DATA_W-1:0] SH_RES,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RESULT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] SLL_SAT = CNT_W'(SLL_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              op_q;
  logic [CNT_W-1:0]  n_eff;
  logic              accept;

  // SLL8 beyond SLL_MAX steps would only shift in more zeros, so clamp the step count.
  always_comb begin
    n_eff = COUNT;
    if (!OP && (COUNT > SLL_SAT)) begin
      n_eff = SLL_SAT;
    end
  end

  assign accept = START && (state != S_RUN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= 1'b0;
    end else if (state == S_RUN) begin
      acc <= SH_RES;
      cnt <= cnt - CNT_ONE;
    end else if (accept) begin
      acc  <= DATA_IN;
      cnt  <= n_eff;
      op_q <= OP;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_nxt = (n_eff != '0) ? S_RUN : S_DONE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt == CNT_ONE) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    SET  = 2'b00;
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state)
      S_RUN: begin
        SET  = op_q ? 2'b10 : 2'b01;
        BUSY = 1'b1;
      end
      S_DONE: DONE = 1'b1;
      default: ;
    endcase
  end

  assign SH_OPND = acc;
  assign RESULT  = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed + randomized bench for shift_sequencer with a behavioural shifter
// and an arithmetic reference model of the N-step result and latency.
module tb_shift_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        OP;
  logic [4:0]  COUNT;
  logic [31:0] DATA_IN;
  logic [31:0] SH_OPND;
  logic [1:0]  SET;
  logic [31:0] SH_RES;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer #(.DATA_W(32), .CNT_W(5), .SLL_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .COUNT(COUNT),
    .DATA_IN(DATA_IN), .SH_OPND(SH_OPND), .SET(SET), .SH_RES(SH_RES),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  // Combinational MIC-1 shifter
  always_comb begin
    case (SET)
      2'b01:   SH_RES = SH_OPND << 8;
      2'b10:   SH_RES = 32'($signed(SH_OPND) >>> 1);
      default: SH_RES = SH_OPND;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    check("set_never_11", 32'(SET == 2'b11), 32'd0);
  end

  function automatic int ref_steps(input logic op, input logic [4:0] count);
    if (op) return int'(count);
    return (count > 5'd4) ? 4 : int'(count);
  endfunction

  function automatic logic [31:0] ref_result(input logic op, input logic [4:0] count,
                                             input logic [31:0] data);
    int n;
    n = ref_steps(op, count);
    if (op) return 32'($signed(data) >>> n);
    if (n >= 4) return 32'd0;
    return data << (8 * n);
  endfunction

  // Called at #1 after an edge (or at negedge); applies a START and follows it to DONE.
  // When scramble is set, inputs (including START) toggle randomly during RUN.
  task automatic run_op(input logic op, input logic [4:0] count, input logic [31:0] data,
                        input bit scramble, input string tag);
    int lat;
    int n;
    logic [31:0] exp;
    n   = ref_steps(op, count);
    exp = ref_result(op, count, data);
    START = 1'b1; OP = op; COUNT = count; DATA_IN = data;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = 1;
    while (!DONE && lat < 64) begin
      check({tag, "_busy"}, 32'(BUSY), 32'd1);
      check({tag, "_set"}, 32'(SET), op ? 32'd2 : 32'd1);
      if (scramble) begin
        START = 1'($urandom); OP = 1'($urandom);
        COUNT = 5'($urandom); DATA_IN = $urandom;
      end
      @(posedge CLK); #1;
      START = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(n + 1));
    check({tag, "_done"}, 32'(DONE), 32'd1);
    check({tag, "_result"}, RESULT, exp);
    check({tag, "_idle_out"}, {30'd0, BUSY, |SET}, 32'd0);
  endtask

  task automatic check_idle_after(input logic [31:0] exp, input string tag);
    START = 1'b0;
    @(posedge CLK); #1;
    check({tag, "_done_drop"}, 32'(DONE), 32'd0);
    check({tag, "_result_hold"}, RESULT, exp);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; OP = 1'b0; COUNT = '0; DATA_IN = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_result", RESULT, 32'd0);
    check("rst_set", 32'(SET), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run_op(1'b1, 5'd1, 32'hAAAA_AAAA, 1'b0, "t1");
    check("t1_value", RESULT, 32'hD555_5555);
    check_idle_after(32'hD555_5555, "t1");

    run_op(1'b0, 5'd3, 32'h1234_5678, 1'b0, "t2");
    check("t2_value", RESULT, 32'h7800_0000);
    check_idle_after(32'h7800_0000, "t2");

    run_op(1'b0, 5'd9, 32'hFFFF_FFFF, 1'b0, "t3");
    check("t3_value", RESULT, 32'h0000_0000);
    check_idle_after(32'h0000_0000, "t3");

    run_op(1'b1, 5'd31, 32'h8000_0000, 1'b0, "t4");
    check("t4_value", RESULT, 32'hFFFF_FFFF);
    run_op(1'b0, 5'd0, 32'hCAFE_F00D, 1'b0, "t4b2b");
    check("t4b2b_value", RESULT, 32'hCAFE_F00D);
    check_idle_after(32'hCAFE_F00D, "t4b2b");

    run_op(1'b1, 5'd6, 32'h0F0F_0000, 1'b1, "t5ign");
    check("t5ign_value", RESULT, 32'h003C_3C00);
    check_idle_after(32'h003C_3C00, "t5ign");

    // Reset mid-RUN discards the partial result and produces no DONE pulse
    START = 1'b1; OP = 1'b1; COUNT = 5'd20; DATA_IN = 32'h1234_0000;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("t5rst_busy_pre", 32'(BUSY), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("t5rst_busy", 32'(BUSY), 32'd0);
    check("t5rst_set", 32'(SET), 32'd0);
    check("t5rst_result", RESULT, 32'd0);
    check("t5rst_done", 32'(DONE), 32'd0);
    for (int i = 0; i < 25; i++) begin
      @(posedge CLK); #1;
      check("t5rst_no_done", 32'(DONE), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic        r_op;
      logic [4:0]  r_cnt;
      logic [31:0] r_data;
      r_op   = 1'($urandom);
      r_cnt  = 5'($urandom);
      r_data = $urandom;
      run_op(r_op, r_cnt, r_data, 1'b1, "rnd");
      if ($urandom_range(0, 1) == 0) begin
        check_idle_after(ref_result(r_op, r_cnt, r_data), "rnd");
      end
    end

    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
